// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared GF(2^8) constants and divider FSM encoding
package gf_pkg;
  localparam int GF_M = 255;
  localparam int GF_SIZE = 8;
  localparam int INV_ITERS = 7;

  // x^8 = x^4 + x^3 + x + 1 (field polynomial 0x11B, high bit implied)
  localparam logic [7:0] GF_RED = 8'h1B;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/gf_mul.sv
// rtl/gf_mul.sv - combinational GF(2^8) multiplier, zero operands give zero
module gf_mul
  import gf_pkg::*;
#(
  parameter int m = GF_M,
  parameter int SIZE = $clog2(m)
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] p
);

  logic [SIZE-1:0] sum;
  logic [SIZE-1:0] x;

  // Shift-and-xor: x walks a * alpha^i with reduction folded into each shift.
  always_comb begin
    sum = '0;
    x = a;
    for (int i = 0; i < SIZE; i++) begin
      if (b[i]) sum = sum ^ x;
      x = {x[SIZE-2:0], 1'b0} ^ (x[SIZE-1] ? GF_RED[SIZE-1:0] : '0);
    end
    p = sum;
  end

endmodule

// File: rtl/gf_div.sv
// rtl/gf_div.sv - sequential GF(2^8) divider q = a * b^254 by square-and-multiply
module gf_div
  import gf_pkg::*;
#(
  parameter int m = GF_M,
  parameter int SIZE = $clog2(m)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] q,
  output logic            div_by_zero
);

  logic [1:0]      state;
  logic [SIZE-1:0] acc;
  logic [SIZE-1:0] sq;
  logic [SIZE-1:0] s2;
  logic [SIZE-1:0] prod;
  logic [2:0]      cnt;
  logic            dbz;

  gf_mul #(.m(m), .SIZE(SIZE)) u_sq (.a(sq), .b(sq), .p(s2));
  gf_mul #(.m(m), .SIZE(SIZE)) u_acc (.a(acc), .b(s2), .p(prod));

  // Invariant in CALC: sq = b^(2^k), acc = a * b^(2 + 4 + ... + 2^k).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      sq    <= '0;
      cnt   <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= a;
            sq    <= b;
            cnt   <= '0;
            dbz   <= (b == '0);
            state <= CALC;
          end
        end
        CALC: begin
          sq  <= s2;
          acc <= prod;
          cnt <= cnt + 3'd1;
          if (cnt == 3'(INV_ITERS - 1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign q           = (state == DONE) ? acc : '0;
  assign div_by_zero = (state == DONE) && dbz;

endmodule

// File: tb/tb_gf_div.sv
// tb/tb_gf_div.sv - self-checking bench for gf_div against a field-arithmetic model
module tb_gf_div;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
  logic       div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] inv_tab [256];

  gf_div dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Polynomial product over GF(2), then long division by 0x11B.
  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (y[i]) p = p ^ (15'(x) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h11B) << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_div(input logic [7:0] x, input logic [7:0] y);
    return (y == 8'h00) ? 8'h00 : ref_mul(x, inv_tab[y]);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1;
    a = x;
    b = y;
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    check("send_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    check(tag, out_valid, 1);
  endtask

  task automatic recv(input string tag, input logic [7:0] eq, input logic edbz);
    wait_out({tag, "_timeout"});
    check({tag, "_q"}, q, eq);
    check({tag, "_dbz"}, div_by_zero, edbz);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] pa, pb, ra, rb, eq;
    logic       have, seen;
    int         n_acc, n_hs, ai, ri;
    logic [7:0] exp_q [$];
    logic       exp_d [$];
    logic [7:0] exp_b [$];
    logic [7:0] exp_a [$];
    logic [7:0] ta [10];
    logic [7:0] tbv [10];
    int         acc_cyc [10];

    for (int y = 1; y < 256; y++)
      for (int x = 1; x < 256; x++)
        if (ref_mul(8'(x), 8'(y)) == 8'h01) inv_tab[y] = 8'(x);
    inv_tab[0] = 8'h00;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #3;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_q", q, 0);
    check("reset_dbz", div_by_zero, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tick();

    // Identity with exact latency: accept at T0, out_valid from T7.
    send(8'h57, 8'h01);
    for (int i = 0; i < 6; i++) tick();
    check("lat_not_early", out_valid, 0);
    tick();
    check("lat_on_time", out_valid, 1);
    recv("id_b1", 8'h57, 1'b0);

    send(8'h9E, 8'h9E);
    recv("self_div", 8'h01, 1'b0);

    send(8'h01, 8'h02);
    wait_out("inv2_timeout");
    check("inv2_roundtrip", ref_mul(q, 8'h02), 8'h01);
    recv("inv2", inv_tab[2], 1'b0);

    send(8'h00, 8'h3C);
    recv("zero_num", 8'h00, 1'b0);
    send(8'h3C, 8'h00);
    recv("zero_den", 8'h00, 1'b1);

    // Reset while computing, then while holding a result.
    send(8'h53, 8'hCA);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("rst_calc_out_valid", out_valid, 0);
    check("rst_calc_q", q, 0);
    check("rst_calc_dbz", div_by_zero, 0);
    check("rst_calc_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin tick(); seen = seen | out_valid; end
    check("rst_no_result", seen, 0);

    send(8'h53, 8'hCA);
    wait_out("rst_done_timeout");
    check("rst_done_q_before", q, ref_div(8'h53, 8'hCA));
    #2 rst = 1'b1;
    #1;
    check("rst_done_out_valid", out_valid, 0);
    check("rst_done_q", q, 0);
    check("rst_done_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Backpressure: result held, new requests ignored.
    send(8'hB7, 8'h4D);
    wait_out("bp_timeout");
    eq = ref_div(8'hB7, 8'h4D);
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0];
      a = 8'($urandom);
      b = 8'($urandom);
      check("bp_q", q, eq);
      check("bp_dbz", div_by_zero, 0);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      tick();
    end
    in_valid = 1'b1; a = 8'h11; b = 8'h22; out_ready = 1'b1;
    check("bp_hs_in_ready", in_ready, 0);
    tick();
    out_ready = 1'b0;
    check("bp_idle_out_valid", out_valid, 0);
    check("bp_idle_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_accepted", in_ready, 0);
    recv("bp_next", ref_div(8'h11, 8'h22), 1'b0);

    // Throughput: continuous traffic, accepts 9 cycles apart.
    for (int i = 0; i < 10; i++) begin
      ta[i] = 8'($urandom);
      tbv[i] = 8'($urandom_range(1, 255));
    end
    ai = 0; ri = 0;
    in_valid = 1'b1; out_ready = 1'b1; a = ta[0]; b = tbv[0];
    for (int c = 0; c < 300 && ri < 10; c++) begin
      have = in_valid && in_ready;
      if (out_valid) begin
        check("tp_q", q, ref_div(ta[ri], tbv[ri]));
        ri++;
      end
      tick();
      if (have) begin
        acc_cyc[ai] = cyc;
        ai++;
        if (ai < 10) begin a = ta[ai]; b = tbv[ai]; end
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    check("tp_results", ri, 10);
    for (int i = 1; i < 10; i++) check("tp_spacing", acc_cyc[i] - acc_cyc[i-1], 9);

    // Random round-trip with random gaps and ignored busy-time requests.
    have = 1'b0; n_acc = 0; n_hs = 0; pa = '0; pb = '0;
    for (int c = 0; c < 20000 && n_hs < 300; c++) begin
      if (in_ready) begin
        if (!have) begin
          pa = 8'($urandom);
          pb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
          have = 1'b1;
        end
        in_valid = ($urandom_range(0, 3) != 0);
        a = pa; b = pb;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        a = 8'($urandom);
        b = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        exp_a.push_back(pa);
        exp_b.push_back(pb);
        exp_q.push_back(ref_div(pa, pb));
        exp_d.push_back(pb == 8'h00);
        have = 1'b0;
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_spurious_out", out_valid, 0);
        end else begin
          ra = exp_a.pop_front();
          rb = exp_b.pop_front();
          check("rnd_q", q, exp_q.pop_front());
          check("rnd_dbz", div_by_zero, exp_d.pop_front());
          if (rb != 8'h00) check("rnd_roundtrip", ref_mul(q, rb), ra);
        end
        n_hs++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("rnd_handshakes", n_hs, 300);
    check("rnd_acc_vs_hs", n_acc, n_hs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
